// File: rtl/user_entropy_serializer.sv
// -----------------------------------------------------------------------------
// user_entropy_serializer
//
// Transmit side of the TRNG user-entropy input. Bytes arrive over a
// valid/ready handshake. Each byte is sent as 8 bits on ent_bit, and every
// bit is qualified by one ent_strobe pulse. The receiver samples ent_bit on
// the rising edge of ent_strobe. Each bit cell is HALF cycles of strobe-low
// (setup) followed by HALF cycles of strobe-high (hold).
//
// Parameters:
//   HALF      - ent_strobe half-period in clk cycles (1..255)
//   LSB_FIRST - 1: bit 0 is sent first, 0: bit 7 is sent first
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   in_data    in   byte to transmit
//   in_valid   in   in_data is valid
//   in_ready   out  byte accepted this cycle if in_valid (combinational)
//   ent_bit    out  serial entropy bit (registered)
//   ent_strobe out  bit clock (registered)
//   busy       out  a byte is being shifted out (registered)
//
// Build option:
//   USER_ENTROPY_SER_HOLDBUF_EN - adds a one-byte holding register so the
//   next byte can be accepted while the current one is shifting. Bytes then
//   follow each other with no IDLE cycle between them.
// -----------------------------------------------------------------------------
module user_entropy_serializer #(
    parameter int unsigned HALF      = 2,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ent_bit,
    output logic       ent_strobe,
    output logic       busy
);

    localparam int unsigned   PW         = $clog2(HALF + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          ent_bit_q, ent_bit_d;
    logic          strobe_q, strobe_d;
    logic          busy_q, busy_d;

`ifdef USER_ENTROPY_SER_HOLDBUF_EN
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
`endif

    logic          take;
    logic          phase_end;
    logic          load_en;
    logic [7:0]    load_byte;

    // Bit idx in transmission order (idx 0 is the first bit on the wire).
    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
        return LSB_FIRST ? b[idx] : b[3'd7 - idx];
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        data_d    = data_q;
        ent_bit_d = ent_bit_q;
        strobe_d  = strobe_q;
        busy_d    = busy_q;
        load_en   = 1'b0;
        load_byte = in_data;
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        in_ready    = !hold_full_q;
`else
        in_ready    = (state_q == S_IDLE);
`endif
        take      = in_valid && in_ready;
        phase_end = (phase_q == PHASE_LAST);

        unique case (state_q)
            S_IDLE: begin
                load_en = take;
            end
            S_SETUP: begin
                phase_d = phase_q + 1'b1;
                if (phase_end) begin
                    phase_d  = '0;
                    state_d  = S_HIGH;
                    strobe_d = 1'b1;
                end
            end
            S_HIGH: begin
                phase_d = phase_q + 1'b1;
                if (phase_end) begin
                    phase_d  = '0;
                    strobe_d = 1'b0;
                    if (idx_q != 3'd7) begin
                        // ent_bit changes only as the strobe falls.
                        idx_d     = idx_q + 3'd1;
                        ent_bit_d = pick_bit(data_q, idx_q + 3'd1);
                        state_d   = S_SETUP;
                    end else begin
                        state_d   = S_IDLE;
                        ent_bit_d = 1'b0;
                        busy_d    = 1'b0;
                        idx_d     = '0;
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
                        // Chain straight into the next byte: from the hold
                        // register if it is full, otherwise from a byte
                        // handed over on this very edge.
                        if (hold_full_q) begin
                            load_en     = 1'b1;
                            load_byte   = hold_q;
                            hold_full_d = 1'b0;
                        end else begin
                            load_en     = take;
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef USER_ENTROPY_SER_HOLDBUF_EN
        // A byte accepted while the shifter is occupied, and not consumed
        // directly above, parks in the hold register.
        if (take && (state_q != S_IDLE) && !load_en) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
`endif

        if (load_en) begin
            data_d    = load_byte;
            ent_bit_d = pick_bit(load_byte, 3'd0);
            busy_d    = 1'b1;
            phase_d   = '0;
            idx_d     = '0;
            strobe_d  = 1'b0;
            state_d   = S_SETUP;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            // NOTE: data_q is a single register, not a memory, so it is
            // reset with everything else to keep the block deterministic.
            data_q    <= '0;
            ent_bit_q <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            ent_bit_q <= ent_bit_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    assign ent_bit    = ent_bit_q;
    assign ent_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_user_entropy_serializer.sv
// -----------------------------------------------------------------------------
// tb_user_entropy_serializer
//
// Four serializer instances with different HALF / bit-order settings:
//   0: HALF=2 LSB-first   1: HALF=1 MSB-first
//   2: HALF=3 LSB-first   3: HALF=4 MSB-first
// A reference model computes, from the handshake rules alone, when each
// offered byte is accepted and when it starts shifting. From that schedule
// it derives the expected in_ready/busy waveforms and the expected list of
// (strobe-rise time, sampled bit) pairs. A monitor records every strobe rise
// and checks that ent_bit is stable for the cycle before and during each
// high phase.
// -----------------------------------------------------------------------------
module tb_user_entropy_serializer;

    logic       clk;
    logic       rst        [4];
    logic [7:0] in_data    [4];
    logic       in_valid   [4];
    logic       in_ready   [4];
    logic       ent_bit    [4];
    logic       ent_strobe [4];
    logic       busy       [4];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int   k;
        int   t;
        logic b;
    } rise_t;

    rise_t      rises[$];
    logic [7:0] stim_q[$];
    logic       prev_s [4];
    logic       prev_b [4];

    user_entropy_serializer #(.HALF(2), .LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ent_bit(ent_bit[0]), .ent_strobe(ent_strobe[0]), .busy(busy[0]));
    user_entropy_serializer #(.HALF(1), .LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ent_bit(ent_bit[1]), .ent_strobe(ent_strobe[1]), .busy(busy[1]));
    user_entropy_serializer #(.HALF(3), .LSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .ent_bit(ent_bit[2]), .ent_strobe(ent_strobe[2]), .busy(busy[2]));
    user_entropy_serializer #(.HALF(4), .LSB_FIRST(1'b0)) u_dut3 (
        .clk(clk), .rst(rst[3]), .in_data(in_data[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .ent_bit(ent_bit[3]), .ent_strobe(ent_strobe[3]), .busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int half_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit lsb_of(input int k);
        return (k == 0) || (k == 2);
    endfunction

    // Expected bit m (0 = first on the wire) of byte b for instance k.
    function automatic logic wire_bit(input int k, input logic [7:0] b, input int m);
        return lsb_of(k) ? b[m] : b[7 - m];
    endfunction

    // Monitor: record every strobe rise; ent_bit must not change on the
    // rising cycle nor while the strobe is high.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ent_strobe[k] === 1'b1)
                check($sformatf("bit_stable%0d", k), ent_bit[k], prev_b[k]);
            if (ent_strobe[k] === 1'b1 && prev_s[k] !== 1'b1)
                rises.push_back('{k: k, t: cyc, b: ent_bit[k]});
            prev_s[k] <= ent_strobe[k];
            prev_b[k] <= ent_bit[k];
        end
    end

    // Offer every byte of stim_q to instance k with in_valid held high, and
    // check handshake, busy and the sampled bit stream against the model.
    task automatic run_stream(input int k);
        int h, n, t0, end_t, c, j, idx, exp_t, ub;
        logic eb, er;
        int acc[$];
        int st[$];
        h = half_of(k);
        n = stim_q.size();
        @(negedge clk);
        t0 = cyc + 1;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                acc.push_back(t0);
                st.push_back(t0);
            end else begin
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
                // Next byte is taken once the hold slot is free; it starts
                // when the previous byte finishes (or at once if idle).
                ub = ((acc[i-1] > st[i-1]) ? acc[i-1] : st[i-1]) + 1;
                acc.push_back(ub);
                st.push_back((ub > st[i-1] + 16*h) ? ub : st[i-1] + 16*h);
`else
                // Next byte is taken on the first IDLE cycle after the last.
                ub = st[i-1] + 16*h + 1;
                acc.push_back(ub);
                st.push_back(ub);
`endif
            end
        end
        end_t = st[n-1] + 16*h;
        rises.delete();
        check($sformatf("ready_pre%0d", k), in_ready[k], 1'b1);
        in_valid[k] = 1'b1;
        in_data[k]  = stim_q[0];
        while (cyc < end_t) begin
            @(negedge clk);
            c  = cyc;
            eb = 1'b0;
            er = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (c >= st[i] && c < st[i] + 16*h) eb = 1'b1;
`ifdef USER_ENTROPY_SER_HOLDBUF_EN
                if (c >= acc[i] && c < st[i]) er = 1'b0;
`else
                if (c >= st[i] && c < st[i] + 16*h) er = 1'b0;
`endif
            end
            check($sformatf("busy%0d", k), busy[k], eb);
            check($sformatf("in_ready%0d", k), in_ready[k], er);
            j = n;
            for (int i = n - 1; i >= 0; i--)
                if (acc[i] > c) j = i;
            if (j < n) begin
                in_valid[k] = 1'b1;
                in_data[k]  = stim_q[j];
            end else begin
                in_valid[k] = 1'b0;
                in_data[k]  = 8'($urandom);
            end
        end
        check($sformatf("idle_bit%0d", k), ent_bit[k], 1'b0);
        check($sformatf("idle_strobe%0d", k), ent_strobe[k], 1'b0);
        check($sformatf("rise_count%0d", k), rises.size(), 8*n);
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 8; m++) begin
                idx   = 8*i + m;
                exp_t = st[i] + h + 2*h*m;
                if (idx < rises.size()) begin
                    check($sformatf("rise_t%0d_b%0d_%0d", k, i, m), rises[idx].t, exp_t);
                    check($sformatf("rise_bit%0d_b%0d_%0d", k, i, m), rises[idx].b,
                          wire_bit(k, stim_q[i], m));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k]      = 1'b1;
            in_valid[k] = 1'b0;
            in_data[k]  = 8'h00;
            prev_s[k]   = 1'b0;
            prev_b[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_bit%0d", k), ent_bit[k], 1'b0);
            check($sformatf("rst_strobe%0d", k), ent_strobe[k], 1'b0);
            check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
            check($sformatf("rst_ready%0d", k), in_ready[k], 1'b1);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // Single byte, LSB first, HALF=2.
        stim_q = '{8'hA5};
        run_stream(0);

        // MSB first, HALF=1.
        stim_q = '{8'h81};
        run_stream(1);

        // Backpressure: 0x3C waits with in_valid high during 0xFF.
        stim_q = '{8'hFF, 8'h3C};
        run_stream(0);

        // Streaming three bytes with in_valid constant.
        stim_q = '{8'h12, 8'h34, 8'h56};
        run_stream(0);

        // Reset in the HIGH phase of bit 3 (HALF=3): rises at t0+3, +9, +15, +21.
        begin
            int t0;
            @(negedge clk);
            rises.delete();
            t0 = cyc + 1;
            in_valid[2] = 1'b1;
            in_data[2]  = 8'h55;
            @(negedge clk);
            in_valid[2] = 1'b0;
            while (cyc < t0 + 21) @(negedge clk);
            check("mid_high_strobe", ent_strobe[2], 1'b1);
            rst[2] = 1'b1;
            @(negedge clk);
            rst[2] = 1'b0;
            check("midrst_strobe", ent_strobe[2], 1'b0);
            check("midrst_bit", ent_bit[2], 1'b0);
            check("midrst_busy", busy[2], 1'b0);
            check("midrst_ready", in_ready[2], 1'b1);
            repeat (10) @(negedge clk);
            check("midrst_rises", rises.size(), 4);
            for (int m = 0; m < 4; m++) begin
                if (m < rises.size()) begin
                    check($sformatf("midrst_t%0d", m), rises[m].t, t0 + 3 + 6*m);
                    check($sformatf("midrst_b%0d", m), rises[m].b, wire_bit(2, 8'h55, m));
                end
            end
        end
        stim_q = '{8'h0F};
        run_stream(2);

        // Reset and transfer on the same edge: the byte is dropped.
        @(negedge clk);
        rises.delete();
        rst[0]      = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hFF;
        @(negedge clk);
        rst[0]      = 1'b0;
        in_valid[0] = 1'b0;
        check("rst_xfer_busy", busy[0], 1'b0);
        check("rst_xfer_ready", in_ready[0], 1'b1);
        check("rst_xfer_bit", ent_bit[0], 1'b0);
        repeat (12) @(negedge clk);
        check("rst_xfer_rises", rises.size(), 0);

        // Random bytes on every instance (HALF 1..4, both bit orders).
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                stim_q.delete();
                for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom));
                run_stream(k);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
